// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and default frame constants
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for the idle-high serial line
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Both flops reset high so a held reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with read handshake and error flags
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       data_valid,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  // Tick counter must reach SB_TICK-1, which exceeds 15 for 1.5/2 stop bits.
  localparam int CW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [CW-1:0] S_MID  = CW'(7);
  localparam logic [CW-1:0] S_BIT  = CW'(15);
  localparam logic [CW-1:0] S_STOP = CW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  rx_state_t       state, state_next;
  logic [CW-1:0]   s_cnt, s_cnt_next;
  logic [2:0]      n_cnt, n_cnt_next;
  logic [DBIT-1:0] b_reg;
  logic [7:0]      dout_next;
  logic            rx_s;
  logic            shift_en;
  logic            frame_done;

  uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
    end else begin
      state <= state_next;
      s_cnt <= s_cnt_next;
      n_cnt <= n_cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == S_MID) begin
            // Line must still be low mid start bit, otherwise it was a glitch.
            if (!rx_s) begin
              state_next = DATA;
              s_cnt_next = '0;
              n_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == S_BIT) begin
            s_cnt_next = '0;
            if (n_cnt == N_LAST) state_next = STOP;
            else                 n_cnt_next = n_cnt + 1'b1;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == S_STOP) state_next = IDLE;
          else                 s_cnt_next = s_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    shift_en   = (state == DATA) && s_tick && (s_cnt == S_BIT);
    frame_done = (state == STOP) && s_tick && (s_cnt == S_STOP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) b_reg <= '0;
    else if (shift_en) begin
      if (DBIT > 1) b_reg <= {rx_s, b_reg[DBIT-1:1]};
      else          b_reg <= rx_s;
    end
  end

  always_comb begin
    dout_next            = '0;
    dout_next[DBIT-1:0]  = b_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout        <= '0;
      data_valid  <= 1'b0;
      rx_done     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_done <= frame_done;
      if (frame_done) begin
        dout       <= dout_next;
        frame_err  <= ~rx_s;
        data_valid <= 1'b1;
      end else if (rd && data_valid) begin
        data_valid <= 1'b0;
      end
      // A read landing on the completion cycle consumed the old byte in time.
      if (frame_done && data_valid && !rd) overrun_err <= 1'b1;
      else if (rd)                         overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       data_valid, rx_done, frame_err, overrun_err, busy;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_ref;
  int w;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd_first;
    logic [7:0] e_dout;
    logic       e_fe;
    logic       e_dv;
    logic       e_ov;
  } vec_t;

  vec_t vecs[5];

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .rd          (rd),
    .dout        (dout),
    .data_valid  (data_valid),
    .rx_done     (rx_done),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Baud timer: one-clk s_tick every 4 clk.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) if (rx_done === 1'b1) done_cnt = done_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // One bit = 16 ticks = 64 clk. A low stop bit is released after 48 clk so
  // the trailing low level cannot be mistaken for the next start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    if (stop) begin
      rx = 1'b1;
      repeat (64) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, rd_first: 1'b0, e_dout: 8'h55, e_fe: 1'b0, e_dv: 1'b1, e_ov: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, rd_first: 1'b1, e_dout: 8'hA3, e_fe: 1'b1, e_dv: 1'b1, e_ov: 1'b0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, rd_first: 1'b0, e_dout: 8'h00, e_fe: 1'b0, e_dv: 1'b1, e_ov: 1'b1};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, rd_first: 1'b1, e_dout: 8'hFF, e_fe: 1'b0, e_dv: 1'b1, e_ov: 1'b0};
    vecs[4] = '{data: 8'h81, stop: 1'b1, rd_first: 1'b1, e_dout: 8'h81, e_fe: 1'b0, e_dv: 1'b1, e_ov: 1'b0};

    idle(5);
    chk("rst_dout", dout, 8'h00);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_rx_done", rx_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun_err", overrun_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    idle(70);

    for (int v = 0; v < 5; v++) begin
      done_ref = done_cnt;
      if (vecs[v].rd_first) pulse_rd();
      send_frame(vecs[v].data, vecs[v].stop);
      idle(64);
      chk($sformatf("v%0d_dout", v), dout, vecs[v].e_dout);
      chk($sformatf("v%0d_frame_err", v), frame_err, vecs[v].e_fe);
      chk($sformatf("v%0d_data_valid", v), data_valid, vecs[v].e_dv);
      chk($sformatf("v%0d_overrun_err", v), overrun_err, vecs[v].e_ov);
      chk($sformatf("v%0d_rx_done_count", v), done_cnt - done_ref, 1);
      chk($sformatf("v%0d_busy", v), busy, 0);
    end

    // Start-bit glitch of 2 clk
    pulse_rd();
    done_ref = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    idle(4);
    chk("glitch_busy", busy, 1);
    w = 0;
    while (busy === 1'b1 && w < 100) begin
      @(negedge clk);
      w = w + 1;
    end
    chk("glitch_back_idle", busy, 0);
    chk("glitch_start_len", (w >= 20 && w <= 40), 1);
    idle(64);
    chk("glitch_rx_done_count", done_cnt - done_ref, 0);
    chk("glitch_data_valid", data_valid, 0);
    chk("glitch_frame_err", frame_err, 0);
    chk("glitch_overrun_err", overrun_err, 0);

    // Back-to-back frames without reading
    done_ref = done_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(64);
    chk("b2b_dout", dout, 8'h22);
    chk("b2b_data_valid", data_valid, 1);
    chk("b2b_overrun_err", overrun_err, 1);
    chk("b2b_rx_done_count", done_cnt - done_ref, 2);
    pulse_rd();
    idle(2);
    chk("b2b_rd_data_valid", data_valid, 0);
    chk("b2b_rd_overrun_err", overrun_err, 0);

    // Read strobe with nothing pending
    pulse_rd();
    idle(2);
    chk("rd_empty_data_valid", data_valid, 0);
    chk("rd_empty_overrun_err", overrun_err, 0);
    chk("rd_empty_dout", dout, 8'h22);

    // Read coincident with completion of the next frame
    send_frame(8'h11, 1'b1);
    idle(64);
    done_ref = done_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        w = 0;
        @(negedge clk);
        #1;
        while (dut.frame_done !== 1'b1 && w < 1000) begin
          @(negedge clk);
          #1;
          w = w + 1;
        end
        rd = 1'b1;
        @(negedge clk);
        #1;
        rd = 1'b0;
      end
    join
    chk("coinc_found_completion", (w < 1000), 1);
    idle(64);
    chk("coinc_dout", dout, 8'h22);
    chk("coinc_data_valid", data_valid, 1);
    chk("coinc_overrun_err", overrun_err, 0);
    chk("coinc_rx_done_count", done_cnt - done_ref, 1);

    // Reset during data bit 4 of 0xFF
    done_ref = done_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (340) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_rx_done", rx_done, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_overrun_err", overrun_err, 0);
        chk("midrst_busy", busy, 0);
        reset = 1'b1;
      end
    join
    idle(64);
    chk("midrst_rx_done_count", done_cnt - done_ref, 0);
    chk("midrst_idle", busy, 0);
    done_ref = done_cnt;
    send_frame(8'h3C, 1'b1);
    idle(64);
    chk("post_rst_dout", dout, 8'h3C);
    chk("post_rst_data_valid", data_valid, 1);
    chk("post_rst_frame_err", frame_err, 0);
    chk("post_rst_overrun_err", overrun_err, 0);
    chk("post_rst_rx_done_count", done_cnt - done_ref, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, s_tick count for the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (reset reset, asynchronous, active-low; clock clk).
REQ-005 SHALL have port s_tick, input, 1, 16x-baud enable pulse, one clk wide, from the baud timer.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rd, input, 1, consumer read strobe, one clk wide.
REQ-008 SHALL have port dout, output, 8, received byte, LSB-aligned, upper 8-DBIT bits zero.
REQ-009 SHALL have port data_valid, output, 1, dout holds an unread byte.
REQ-010 SHALL have port rx_done, output, 1, one-clk pulse at frame completion.
REQ-011 SHALL have port frame_err, output, 1, stop bit sampled low for the frame in dout.
REQ-012 SHALL have port overrun_err, output, 1, a byte was overwritten before being read.
REQ-013 SHALL have port busy, output, 1, FSM not in IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (flops reset to 1); FSM uses only rx_s, which lags rx by 2 clk.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, with a 4-bit tick counter s_cnt and a 3-bit bit counter n_cnt.
REQ-016 IDLE: on rx_s==0 SHALL go to START with s_cnt=0, independent of s_tick.
REQ-017 START: on s_tick with s_cnt==7, SHALL go to DATA with s_cnt=0 and n_cnt=0 if rx_s==0, else return to IDLE (glitch reject, no flags); on other s_tick, s_cnt+1.
REQ-018 DATA: on s_tick with s_cnt==15, SHALL shift rx_s into the shift register LSB-first, set s_cnt=0, and go to STOP if n_cnt==DBIT-1, else n_cnt+1.
REQ-019 STOP: on s_tick with s_cnt==SB_TICK-1 (counter widened to hold SB_TICK-1), SHALL sample rx_s, go to IDLE, and complete the frame.
REQ-020 Cycles without s_tick SHALL leave s_cnt, n_cnt and state unchanged, except the IDLE exit.
REQ-021 At frame completion, registered outputs SHALL update on the next clk edge: dout loads the byte, frame_err = ~sampled stop, rx_done=1 for exactly one clk, data_valid=1.
REQ-022 rx_done and dout SHALL be produced even when frame_err=1.
REQ-023 rd with data_valid=1 SHALL clear data_valid next clk; rd with data_valid=0 SHALL be ignored.
REQ-024 Completion while data_valid=1 and rd=0 SHALL set overrun_err and overwrite dout.
REQ-025 Completion in the same cycle as rd SHALL leave data_valid=1 and SHALL NOT set overrun_err.
REQ-026 overrun_err SHALL be sticky; it SHALL clear only on rd or reset.
REQ-027 An rx_s low after STOP SHALL start a new frame immediately (back-to-back frames, no idle gap required).

Reset
REQ-028 While reset=0, SHALL force the FSM to IDLE, counters to 0, and synchronizer flops to 1.
REQ-029 While reset=0, SHALL hold dout=0, data_valid=0, rx_done=0, frame_err=0, overrun_err=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no rx_done.

Structure
REQ-031 SHALL place the state enum typedef and the DBIT/SB_TICK default constants in shared package uart_pkg.
REQ-032 SHALL implement the synchronizer as sub-module uart_sync; the baud timer SHALL be instantiated by the parent, not inside uart_rx.

Verification
REQ-033 Frame 0x55, 1 stop, s_tick every 4 clk -> one rx_done, dout=0x55, data_valid=1, frame_err=0.
REQ-034 2-clk low glitch on idle rx -> FSM returns to IDLE after 8 s_ticks, no rx_done, flags 0.
REQ-035 Frame 0xA3 with stop bit driven low -> rx_done, dout=0xA3, frame_err=1.
REQ-036 Frames 0x11 then 0x22 back-to-back, no rd -> dout=0x22, overrun_err=1; rd -> data_valid=0, overrun_err=0.
REQ-037 rd coincident with 0x22 completion -> data_valid=1, overrun_err=0.
REQ-038 reset=0 during data bit 4 of 0xFF -> all outputs 0, next clean 0x3C frame received correctly.
